// File: rtl/stonyman_capture.sv
// Stonyman frame-capture sequencer: walks the sensor pointer/value registers in
// raster order, triggers one ADC conversion per pixel and pushes it into the FIFO.
module stonyman_capture #(
    parameter int unsigned ROWS          = 112,
    parameter int unsigned COLS          = 112,
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic       PCLK,
    input  logic       PRESERN,
    input  logic       START_CAPTURE,
    output logic       BUSY,
    input  logic       FULL,
    output logic       WREN,
    output logic [7:0] PIXELOUT,
    output logic       RESP,
    output logic       INCP,
    output logic       RESV,
    output logic       INCV,
    output logic       ADC_START,
    input  logic       ADC_DONE,
    input  logic [7:0] ADC_DATA
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 8;
    localparam logic [CNT_W-1:0] PULSE_FALL  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(2 * PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_ROW    = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_COL    = IDX_W'(COLS - 1);

    // One-hot control line codes, bit order {RESP, INCP, RESV, INCV}
    localparam logic [3:0] C_RESP = 4'b1000;
    localparam logic [3:0] C_INCP = 4'b0100;
    localparam logic [3:0] C_RESV = 4'b0010;
    localparam logic [3:0] C_INCV = 4'b0001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ROW_RESP,
        S_ROW_INCP,
        S_ROW_RESV,
        S_ROW_INCV,
        S_COL_RESP,
        S_COL_RESV,
        S_COL_INCV,
        S_SETTLE,
        S_CONV,
        S_WAIT_ADC,
        S_PUSH,
        S_WRITE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] incv_cnt;
    logic [3:0]       ctrl;

    assign RESP = ctrl[3];
    assign INCP = ctrl[2];
    assign RESV = ctrl[1];
    assign INCV = ctrl[0];

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            incv_cnt  <= '0;
            ctrl      <= '0;
            BUSY      <= 1'b0;
            WREN      <= 1'b1;
            PIXELOUT  <= '0;
            ADC_START <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!START_CAPTURE) begin
                        state <= S_ROW_RESP;
                        BUSY  <= 1'b1;
                        ctrl  <= C_RESP;
                        cnt   <= '0;
                        row   <= '0;
                        col   <= '0;
                    end
                end

                // Pulse states: line high for PULSE_CYCLES, then low for PULSE_CYCLES
                S_ROW_RESP, S_ROW_INCP, S_ROW_RESV, S_ROW_INCV,
                S_COL_RESP, S_COL_RESV, S_COL_INCV: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == PULSE_FALL) begin
                        ctrl <= '0;
                    end
                    if (cnt == PULSE_LAST) begin
                        cnt <= '0;
                        case (state)
                            S_ROW_RESP: begin
                                state <= S_ROW_INCP;
                                ctrl  <= C_INCP;
                            end
                            S_ROW_INCP: begin
                                state <= S_ROW_RESV;
                                ctrl  <= C_RESV;
                            end
                            S_ROW_RESV: begin
                                if (row == '0) begin
                                    state <= S_COL_RESP;
                                    ctrl  <= C_RESP;
                                end else begin
                                    state    <= S_ROW_INCV;
                                    ctrl     <= C_INCV;
                                    incv_cnt <= IDX_W'(1);
                                end
                            end
                            S_ROW_INCV: begin
                                if (incv_cnt == row) begin
                                    state <= S_COL_RESP;
                                    ctrl  <= C_RESP;
                                end else begin
                                    incv_cnt <= incv_cnt + IDX_W'(1);
                                    ctrl     <= C_INCV;
                                end
                            end
                            S_COL_RESP: begin
                                state <= S_COL_RESV;
                                ctrl  <= C_RESV;
                            end
                            S_COL_RESV: begin
                                state <= S_SETTLE;
                                col   <= '0;
                            end
                            S_COL_INCV: begin
                                state <= S_SETTLE;
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end

                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt       <= '0;
                        state     <= S_CONV;
                        ADC_START <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_CONV: begin
                    ADC_START <= 1'b0;
                    state     <= S_WAIT_ADC;
                end

                S_WAIT_ADC: begin
                    if (ADC_DONE) begin
                        PIXELOUT <= ADC_DATA;
                        state    <= S_PUSH;
                    end
                end

                // Stall here with the pixel held until the FIFO has room
                S_PUSH: begin
                    if (!FULL) begin
                        WREN  <= 1'b0;
                        state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    WREN <= 1'b1;
                    cnt  <= '0;
                    if (col != LAST_COL) begin
                        col   <= col + IDX_W'(1);
                        ctrl  <= C_INCV;
                        state <= S_COL_INCV;
                    end else if (row != LAST_ROW) begin
                        row   <= row + IDX_W'(1);
                        ctrl  <= C_RESP;
                        state <= S_ROW_RESP;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/stonyman_capture.md
Name: stonyman_capture

Overview:
Frame-capture sequencer that drives the Stonyman image sensor's pointer/value register interface. It triggers an external 8-bit ADC once per pixel and pushes each pixel into the pixel FIFO. The APB-side driver on the same FIFO reads the pixels out and issues START_CAPTURE. One capture walks the full ROWS x COLS array in raster order (row-major, column 0 first).

Parameters:
ROWS, 112, rows per frame (1..255)
COLS, 112, columns per frame (1..255)
PULSE_CYCLES, 2, PCLK cycles each sensor control pulse is high, and minimum low time between pulses (>=1)
SETTLE_CYCLES, 8, PCLK cycles waited after selecting a pixel before ADC start (>=1)

Ports:
PCLK  in  1  clock
PRESERN  in  1  reset, synchronous, active-low
START_CAPTURE  in  1  active low; sampled on every PCLK edge
BUSY  out  1  high while a frame is in progress
FULL  in  1  pixel FIFO full, active high
WREN  out  1  FIFO write enable, active low, one cycle per pixel
PIXELOUT  out  8  pixel data to FIFO, valid while WREN low
RESP  out  1  sensor pointer reset pulse, active high
INCP  out  1  sensor pointer increment pulse, active high
RESV  out  1  sensor value reset pulse, active high
INCV  out  1  sensor value increment pulse, active high
ADC_START  out  1  one-cycle convert request, active high
ADC_DONE  in  1  conversion complete strobe, active high
ADC_DATA  in  8  conversion result, valid when ADC_DONE high

Behaviour:
- Reset (PRESERN low at a PCLK edge): state IDLE, row/col/pulse/settle counters 0. BUSY=0, WREN=1, PIXELOUT=0, RESP=INCP=RESV=INCV=0, ADC_START=0. Reset mid-frame aborts immediately; no partial write completes.
- Pulse primitive: control line high PULSE_CYCLES cycles, then low PULSE_CYCLES cycles before the next state. At most one of RESP/INCP/RESV/INCV is high at any time.
- IDLE: START_CAPTURE==0 -> ROW_RESP, BUSY=1 from the next cycle. START_CAPTURE is ignored while BUSY=1.
- ROW_RESP (RESP pulse) -> ROW_INCP (one INCP; pointer = ROWSEL, reg 1) -> ROW_RESV (RESV pulse) -> ROW_INCV (exactly row INCV pulses; zero pulses for row 0) -> COL_RESP.
- COL_RESP (RESP pulse; pointer = COLSEL, reg 0) -> COL_RESV (RESV pulse; col=0) -> SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles -> CONV.
- CONV: ADC_START=1 for exactly one cycle -> WAIT_ADC.
- WAIT_ADC: on a cycle with ADC_DONE=1, register ADC_DATA into PIXELOUT -> PUSH. No timeout. ADC_DONE is ignored in every other state.
- PUSH: if FULL=0, WREN=0 for exactly one cycle with PIXELOUT stable, then proceed. If FULL=1, hold WREN=1 and PIXELOUT unchanged until FULL=0. No pixel is ever dropped or duplicated.
- After a push:
  - col<COLS-1: INCV pulse, col+1, -> SETTLE.
  - col==COLS-1 and row<ROWS-1: row+1 -> ROW_RESP.
  - Last pixel: -> IDLE, BUSY=0 on the following cycle.
- Exactly ROWS*COLS FIFO writes per frame.
- Counters are 8-bit and never wrap within a frame.

Test Plan:
- ROWS=2, COLS=3, PULSE_CYCLES=1, SETTLE_CYCLES=2; ADC returns 8'h10+k for the k-th conversion, FULL=0; pulse START_CAPTURE low one cycle -> 6 WREN low cycles with PIXELOUT 10,11,12,13,14,15; BUSY high throughout, low after the last write.
- Same frame, count pulses -> RESP=4, INCP=2, RESV=4, INCV=1 (row 1) + 4 (column steps) = 5; each pulse exactly 1 cycle high; never two control lines high together.
- Hold FULL=1 for 20 cycles at the 2nd pixel -> WREN stays high, PIXELOUT holds 11; a single write of 11 in the cycle after FULL drops; total still 6 writes.
- ADC_DONE delayed 50 cycles after ADC_START -> no write and no ADC_START re-issue in the interim; ADC_START seen exactly 6 times per frame.
- START_CAPTURE low again mid-frame -> ignored; frame completes with 6 writes; a second START after BUSY falls starts a new frame.
- PRESERN low for 1 cycle during ROW_INCV -> next cycle BUSY=0, all control lines 0, WREN=1; restart yields a full correct 6-pixel frame.
